// File: rtl/lsu_bram_ctrl.sv
// lsu_bram_ctrl: load/store initiator between the memory stage and four
// byte-lane data BRAM banks (bank i holds byte i of every word).
//
// Ports:
//   CLK, RST                 clock, async active-high reset
//   REQ_VALID/READY          request handshake
//   REQ_WE, REQ_FUNCT3       store/load, RV32 size + signedness
//   REQ_ADDR, REQ_WDATA      byte address, LSB-aligned store data
//   RSP_VALID/READY          response handshake
//   RSP_RDATA, RSP_ERR       extended load data, illegal-funct3 flag
//   BANK_W_ADDR/R_ADDR       per-lane word addresses, packed lane-major
//   BANK_WE/RE               per-lane enables
//   BANK_DIN/DOUT            per-lane bytes; DOUT is registered (1-cycle)

// One lane: which request byte lands here, and at which word.
module lsu_bram_lane #(
  parameter int WA   = 6,
  parameter int LANE = 0
) (
  input  logic [1:0]    ofs,
  input  logic [WA-1:0] word,
  input  logic [2:0]    nbytes,
  input  logic [31:0]   wdata,
  output logic          used,
  output logic [WA-1:0] addr,
  output logic [7:0]    din
);
  logic [1:0] k;

  // k = (LANE - ofs) mod 4 is the request byte index mapped to this lane
  assign k    = 2'(LANE) - ofs;
  assign used = ({1'b0, k} < nbytes);
  // a used lane below the start offset holds bytes that spilled into the
  // next word; the WA-bit add wraps top-of-memory back to word 0
  assign addr = (used && (2'(LANE) < ofs)) ? word + WA'(1) : word;
  assign din  = wdata[8*k +: 8];
endmodule

module lsu_bram_ctrl #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      REQ_VALID,
  output logic                      REQ_READY,
  input  logic                      REQ_WE,
  input  logic [2:0]                REQ_FUNCT3,
  input  logic [ADDR_WIDTH-1:0]     REQ_ADDR,
  input  logic [31:0]               REQ_WDATA,
  output logic                      RSP_VALID,
  input  logic                      RSP_READY,
  output logic [31:0]               RSP_RDATA,
  output logic                      RSP_ERR,
  output logic [4*(ADDR_WIDTH-2)-1:0] BANK_W_ADDR,
  output logic [4*(ADDR_WIDTH-2)-1:0] BANK_R_ADDR,
  output logic [3:0]                BANK_WE,
  output logic [3:0]                BANK_RE,
  output logic [31:0]               BANK_DIN,
  input  logic [31:0]               BANK_DOUT
);
  localparam int WA = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;
  state_t state, state_nxt;

  logic          accept, legal;
  logic [2:0]    nbytes;
  logic [1:0]    ofs;
  logic [WA-1:0] word;
  logic [3:0]    used;
  logic          capture;

  // registered request attributes for load formatting
  logic [1:0]  ofs_q, size_q;
  logic        sgn_q, load_q, err_q;
  logic [31:0] hold_data;
  logic        hold_err;

  logic [63:0] dbl;
  logic [31:0] rot, ext, fmt;

  assign ofs  = REQ_ADDR[1:0];
  assign word = REQ_ADDR[ADDR_WIDTH-1:2];

  always_comb begin
    nbytes = 3'd0;
    case (REQ_FUNCT3[1:0])
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
  end

  // stores: SB/SH/SW only; loads additionally LBU/LHU
  assign legal = REQ_WE ? (REQ_FUNCT3[2] == 1'b0 && REQ_FUNCT3[1:0] != 2'b11)
                        : (REQ_FUNCT3[1:0] != 2'b11 &&
                           !(REQ_FUNCT3[2] && REQ_FUNCT3[1]));

  assign accept = REQ_VALID && REQ_READY;

  genvar l;
  generate
    for (l = 0; l < 4; l++) begin : g_lane
      logic [WA-1:0] addr;
      lsu_bram_lane #(.WA(WA), .LANE(l)) u_lane (
        .ofs    (ofs),
        .word   (word),
        .nbytes (nbytes),
        .wdata  (REQ_WDATA),
        .used   (used[l]),
        .addr   (addr),
        .din    (BANK_DIN[8*l +: 8])
      );
      assign BANK_W_ADDR[l*WA +: WA] = addr;
      assign BANK_R_ADDR[l*WA +: WA] = addr;
      assign BANK_WE[l] = accept && legal &&  REQ_WE && used[l];
      assign BANK_RE[l] = accept && legal && !REQ_WE && used[l];
    end
  endgenerate

  // rotate so that request byte 0 sits at bits [7:0]
  assign dbl = {BANK_DOUT, BANK_DOUT} >> (8 * ofs_q);
  assign rot = dbl[31:0];

  always_comb begin
    ext = rot;
    case (size_q)
      2'b00:   ext = sgn_q ? {{24{rot[7]}},  rot[7:0]}  : {24'd0, rot[7:0]};
      2'b01:   ext = sgn_q ? {{16{rot[15]}}, rot[15:0]} : {16'd0, rot[15:0]};
      default: ext = rot;
    endcase
  end

  assign fmt = (load_q && !err_q) ? ext : 32'd0;

  // RESP stalled: BANK_DOUT may be overwritten later, so freeze the result
  assign capture = (state == RESP) && !RSP_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      ofs_q     <= 2'd0;
      size_q    <= 2'd0;
      sgn_q     <= 1'b0;
      load_q    <= 1'b0;
      err_q     <= 1'b0;
      hold_data <= 32'd0;
      hold_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ofs_q  <= ofs;
        size_q <= REQ_FUNCT3[1:0];
        sgn_q  <= !REQ_FUNCT3[2];
        load_q <= !REQ_WE;
        err_q  <= !legal;
      end
      if (capture) begin
        hold_data <= fmt;
        hold_err  <= err_q;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    REQ_READY = 1'b0;
    RSP_VALID = 1'b0;
    RSP_RDATA = 32'd0;
    RSP_ERR   = 1'b0;
    case (state)
      IDLE: begin
        REQ_READY = !RST;
        if (REQ_VALID && !RST) state_nxt = RESP;
      end
      RESP: begin
        RSP_VALID = 1'b1;
        RSP_RDATA = fmt;
        RSP_ERR   = err_q;
        // a new accept here is safe: the consumer retires this response now
        REQ_READY = RSP_READY && !RST;
        if (RSP_READY) state_nxt = (REQ_VALID && !RST) ? RESP : IDLE;
        else           state_nxt = HOLD;
      end
      HOLD: begin
        RSP_VALID = 1'b1;
        RSP_RDATA = hold_data;
        RSP_ERR   = hold_err;
        if (RSP_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // outputs are quiet while reset is held
    if (RST) begin
      RSP_VALID = 1'b0;
      RSP_RDATA = 32'd0;
      RSP_ERR   = 1'b0;
    end
  end
endmodule
